// File: rtl/t05_1602_lcd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : t05_1602_lcd_ctrl_if                                         |
// | Description : Host request bus plus SPI byte-transmitter handshake for the |
// |               1602 LCD controller. The slave modport is the controller;    |
// |               the master modport is whatever drives requests and models    |
// |               the transmitter.                                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface t05_1602_lcd_ctrl_if;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       init_done;
  logic       spi_start;
  logic [7:0] spi_data;
  logic       spi_busy;
  logic       spi_done;

  modport slave (
    input  req_valid, req_rs, req_data, spi_busy, spi_done,
    output req_ready, init_done, spi_start, spi_data
  );

  modport master (
    output req_valid, req_rs, req_data, spi_busy, spi_done,
    input  req_ready, init_done, spi_start, spi_data
  );
endinterface
`default_nettype wire

// File: rtl/t05_1602_lcd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : t05_1602_lcd_ctrl                                            |
// | Description : HD44780 1602 LCD sequencer in 4-bit mode over an SPI port    |
// |               expander. Power-up wait, fixed init list, then host bytes,   |
// |               each split into E-strobed nibble frames with exec delays.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module t05_1602_lcd_ctrl #(
  parameter int POWERUP_CYC    = 400000,
  parameter int INIT_WAIT_CYC  = 41000,
  parameter int SHORT_WAIT_CYC = 400,
  parameter int LONG_WAIT_CYC  = 16000,
  parameter bit BACKLIGHT      = 1'b1
) (
  input wire clk,
  input wire rst_n,
  t05_1602_lcd_ctrl_if.slave bus
);

  // One counter serves the power-up wait and every execution delay.
  localparam int c_MAX_A = (POWERUP_CYC > INIT_WAIT_CYC) ? POWERUP_CYC : INIT_WAIT_CYC;
  localparam int c_MAX_B = (LONG_WAIT_CYC > SHORT_WAIT_CYC) ? LONG_WAIT_CYC : SHORT_WAIT_CYC;
  localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CNT_W = $clog2(c_MAX + 1);

  // Terminal counts: a wait of N cycles runs the counter 0..N-1.
  localparam logic [c_CNT_W-1:0] c_PWR_TERM   = c_CNT_W'(POWERUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_INIT_TERM  = c_CNT_W'(INIT_WAIT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_SHORT_TERM = c_CNT_W'(SHORT_WAIT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LONG_TERM  = c_CNT_W'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP     = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DELAY     = 3'd4,
    S_READY     = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   r_term;
  logic [2:0]           r_entry;
  logic                 r_init;
  logic [7:0]           r_byte;
  logic                 r_rs;
  logic                 r_nib;
  logic [1:0]           r_frame;
  logic                 r_req_ready;
  logic                 r_init_done;
  logic                 r_spi_start;
  logic [7:0]           r_spi_data;

  logic [7:0]           w_ie_byte;
  logic                 w_ie_nib;
  logic [c_CNT_W-1:0]   w_ie_term;
  logic [c_CNT_W-1:0]   w_host_term;
  logic                 w_last;
  logic [1:0]           w_next_frame;

  // Frame layout {nibble, BL, E, RW=0, RS}; even frames raise E, odd frames drop it,
  // frames 0/1 carry the high nibble and 2/3 the low nibble.
  function automatic logic [7:0] f_frame(input logic [7:0] b, input logic rs,
                                         input logic [1:0] idx);
    logic [3:0] n;
    n = idx[1] ? b[3:0] : b[7:4];
    return {n, BACKLIGHT, ~idx[0], 1'b0, rs};
  endfunction

  // Init list decode; nibble entries hold their nibble in the high half of the byte.
  always_comb begin
    w_ie_byte = 8'h00;
    w_ie_nib  = 1'b0;
    w_ie_term = c_SHORT_TERM;
    case (r_entry)
      3'd0, 3'd1, 3'd2: begin
        w_ie_byte = 8'h30;
        w_ie_nib  = 1'b1;
        w_ie_term = c_INIT_TERM;
      end
      3'd3: begin
        w_ie_byte = 8'h20;
        w_ie_nib  = 1'b1;
      end
      3'd4:    w_ie_byte = 8'h28;
      3'd5:    w_ie_byte = 8'h0C;
      3'd6:    w_ie_byte = 8'h06;
      default: begin
        w_ie_byte = 8'h01;
        w_ie_term = c_LONG_TERM;
      end
    endcase
  end

  // Clear and home commands need the long execution time.
  assign w_host_term  = (!bus.req_rs && (bus.req_data == 8'h01 || bus.req_data == 8'h02 ||
                                         bus.req_data == 8'h03)) ? c_LONG_TERM : c_SHORT_TERM;
  assign w_last       = r_nib ? (r_frame == 2'd1) : (r_frame == 2'd3);
  assign w_next_frame = r_frame + 2'd1;

  // Main sequencer: power-up, init list, host bytes, frame handshake and delays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_term      <= '0;
      r_entry     <= 3'd0;
      r_init      <= 1'b1;
      r_byte      <= 8'h00;
      r_rs        <= 1'b0;
      r_nib       <= 1'b0;
      r_frame     <= 2'd0;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
      r_spi_start <= 1'b0;
      r_spi_data  <= 8'h00;
    end else begin
      r_spi_start <= 1'b0;
      case (r_state)
        S_PWRUP: begin
          if (r_cnt == c_PWR_TERM) begin
            r_cnt   <= '0;
            r_entry <= 3'd0;
            r_state <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_byte     <= w_ie_byte;
          r_nib      <= w_ie_nib;
          r_term     <= w_ie_term;
          r_rs       <= 1'b0;
          r_frame    <= 2'd0;
          r_spi_data <= f_frame(w_ie_byte, 1'b0, 2'd0);
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (!bus.spi_busy) begin
            r_spi_start <= 1'b1;
            r_state     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.spi_done) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_DELAY;
            end else begin
              r_frame    <= w_next_frame;
              r_spi_data <= f_frame(r_byte, r_rs, w_next_frame);
              r_state    <= S_SEND;
            end
          end
        end
        S_DELAY: begin
          if (r_cnt == r_term) begin
            r_cnt <= '0;
            if (r_init && r_entry != 3'd7) begin
              r_entry <= r_entry + 3'd1;
              r_state <= S_LOAD;
            end else begin
              r_init      <= 1'b0;
              r_req_ready <= 1'b1;
              r_init_done <= 1'b1;
              r_state     <= S_READY;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READY: begin
          // The first frame launches straight from the accept so spi_start follows next cycle.
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_byte      <= bus.req_data;
            r_rs        <= bus.req_rs;
            r_nib       <= 1'b0;
            r_frame     <= 2'd0;
            r_term      <= w_host_term;
            r_spi_data  <= f_frame(bus.req_data, bus.req_rs, 2'd0);
            if (!bus.spi_busy) begin
              r_spi_start <= 1'b1;
              r_state     <= S_WAIT_DONE;
            end else begin
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_PWRUP;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.init_done = r_init_done;
  assign bus.spi_start = r_spi_start;
  assign bus.spi_data  = r_spi_data;

endmodule
`default_nettype wire
